// File: rtl/jam_cost_host.sv
// Host side of the JAM engine: loads the 8x8 cost table over a valid/ready stream,
// runs the engine out of reset, serves Cost lookups and captures the result or a timeout.
module jam_cost_host #(
   parameter int unsigned TIMEOUT = 400000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ld_valid,
   input  logic [6:0]  ld_data,
   output logic        ld_ready,
   output logic        jam_rst,
   input  logic [2:0]  W,
   input  logic [2:0]  J,
   output logic [6:0]  Cost,
   input  logic        Valid,
   input  logic [9:0]  MinCost,
   input  logic [3:0]  MatchCount,
   output logic        done,
   output logic        err,
   output logic [9:0]  res_min,
   output logic [3:0]  res_cnt,
   output logic [19:0] run_cycles
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [19:0] TO_LAST = 20'(TIMEOUT - 1);
   localparam logic [19:0] TO_VAL  = 20'(TIMEOUT);

   state_t      state_q, state_d;
   logic [5:0]  idx_q;
   logic [5:0]  wr_idx;
   logic [19:0] cnt_q;
   logic [6:0]  table_q [64];
   logic        accept;
   logic        timeout_hit;

   assign ld_ready    = (state_q != RUN);
   assign accept      = ld_valid & ld_ready;
   // A load begun from IDLE or DONE always lands at index 0, whatever idx_q holds.
   assign wr_idx      = (state_q == LOAD) ? idx_q : '0;
   assign timeout_hit = (cnt_q == TO_LAST);
   assign Cost        = table_q[{W, J}];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LOAD;
         LOAD:    if (accept && idx_q == 6'd63) state_d = RUN;
         RUN:     if (Valid || timeout_hit) state_d = DONE;
         DONE:    if (accept) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         jam_rst    <= 1'b1;
         idx_q      <= '0;
         cnt_q      <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         res_min    <= '0;
         res_cnt    <= '0;
         run_cycles <= '0;
      end else begin
         state_q <= state_d;
         jam_rst <= (state_d != RUN);
         if (accept) idx_q <= wr_idx + 6'd1;

         if (state_q != RUN)    cnt_q <= '0;
         else if (cnt_q != '1) cnt_q <= cnt_q + 20'd1;

         if (state_q == RUN) begin
            if (Valid) begin
               res_min    <= MinCost;
               res_cnt    <= MatchCount;
               run_cycles <= cnt_q;
               done       <= 1'b1;
               err        <= 1'b0;
            end else if (timeout_hit) begin
               run_cycles <= TO_VAL;
               done       <= 1'b1;
               err        <= 1'b1;
            end
         end else if (state_q == DONE && accept) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
      end
   end

   // Table is not reset; every run is preceded by a full rewrite.
   always_ff @(posedge CLK) begin
      if (accept) table_q[wr_idx] <= ld_data;
   end

endmodule

// File: tb/tb_jam_cost_host.sv
// Directed bench for jam_cost_host: loads, Cost lookups, result capture, timeout,
// mid-load reset and reload from DONE, with a stub engine driven from the bench.
module tb_jam_cost_host;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ld_valid;
   logic [6:0]  ld_data;
   logic        ld_ready;
   logic        jam_rst;
   logic [2:0]  W, J;
   logic [6:0]  Cost;
   logic        Valid;
   logic [9:0]  MinCost;
   logic [3:0]  MatchCount;
   logic        done, err;
   logic [9:0]  res_min;
   logic [3:0]  res_cnt;
   logic [19:0] run_cycles;

   int tests = 0;
   int fails = 0;

   logic [6:0]  mdl [64];
   logic [9:0]  exp_min;
   logic [3:0]  exp_cnt;
   logic [19:0] exp_cyc;

   jam_cost_host #(.TIMEOUT(1000)) dut (
      .CLK(CLK), .RST(RST),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
      .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
      .done(done), .err(err), .res_min(res_min), .res_cnt(res_cnt),
      .run_cycles(run_cycles)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_jam_rst", 32'(jam_rst), 1);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_res_min", 32'(res_min), 0);
      check("rst_res_cnt", 32'(res_cnt), 0);
      check("rst_run_cycles", 32'(run_cycles), 0);
      check("rst_ld_ready", 32'(ld_ready), 1);
   endtask

   // kind 0: diagonal (0 on W==J else 100); kind 1: all 127
   task automatic load(input int kind, input bit gaps);
      for (int i = 0; i < 64; i++) begin
         if (kind == 0) mdl[i] = ((i / 8) == (i % 8)) ? 7'd0 : 7'd100;
         else           mdl[i] = 7'd127;
         if (gaps && (i % 3 == 1)) begin
            ld_valid = 1'b0;
            ld_data  = 7'h55;
            repeat (1 + i % 2) begin
               @(posedge CLK); #1;
               check("gap_ld_ready", 32'(ld_ready), 1);
               check("gap_jam_rst", 32'(jam_rst), 1);
            end
         end
         check("load_ld_ready", 32'(ld_ready), 1);
         check("load_jam_rst", 32'(jam_rst), 1);
         ld_valid = 1'b1;
         ld_data  = mdl[i];
         @(posedge CLK); #1;
         if (i == 0) begin
            check("first_done_clr", 32'(done), 0);
            check("first_err_clr", 32'(err), 0);
            check("hold_res_min", 32'(res_min), 32'(exp_min));
            check("hold_res_cnt", 32'(res_cnt), 32'(exp_cnt));
            check("hold_run_cycles", 32'(run_cycles), 32'(exp_cyc));
         end
      end
      ld_valid = 1'b0;
      check("run_ld_ready", 32'(ld_ready), 0);
      check("run_jam_rst", 32'(jam_rst), 0);
      check("run_done", 32'(done), 0);
   endtask

   // Sweep every (W,J) for 64 RUN cycles, then present a result.
   task automatic run_and_finish(input logic [9:0] mc, input logic [3:0] cnt);
      for (int k = 0; k < 64; k++) begin
         W = 3'(k >> 3);
         J = 3'(k);
         #1;
         check("cost", 32'(Cost), 32'(mdl[k]));
         check("run_ld_ready_hold", 32'(ld_ready), 0);
         check("run_jam_rst_hold", 32'(jam_rst), 0);
         @(posedge CLK); #1;
      end
      check("done_before_valid", 32'(done), 0);
      Valid      = 1'b1;
      MinCost    = mc;
      MatchCount = cnt;
      @(posedge CLK); #1;
      Valid = 1'b0;
      exp_min = mc;
      exp_cnt = cnt;
      exp_cyc = 20'd64;
      check("cap_done", 32'(done), 1);
      check("cap_err", 32'(err), 0);
      check("cap_res_min", 32'(res_min), 32'(exp_min));
      check("cap_res_cnt", 32'(res_cnt), 32'(exp_cnt));
      check("cap_run_cycles", 32'(run_cycles), 32'(exp_cyc));
      check("cap_jam_rst", 32'(jam_rst), 1);
      check("cap_ld_ready", 32'(ld_ready), 1);
      // Valid outside RUN must be ignored
      Valid      = 1'b1;
      MinCost    = 10'h3ff;
      MatchCount = 4'hf;
      @(posedge CLK); #1;
      Valid = 1'b0;
      check("done_ign_min", 32'(res_min), 32'(exp_min));
      check("done_ign_cnt", 32'(res_cnt), 32'(exp_cnt));
      check("done_hold", 32'(done), 1);
   endtask

   initial begin
      int k;
      RST = 1'b1; ld_valid = 1'b0; ld_data = '0; W = '0; J = '0;
      Valid = 1'b0; MinCost = '0; MatchCount = '0;
      exp_min = '0; exp_cnt = '0; exp_cyc = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      check_reset_vals();

      // diagonal, back-to-back
      load(0, 1'b0);
      run_and_finish(10'd0, 4'd1);

      // reload from DONE with all-127, gapped
      load(1, 1'b1);
      run_and_finish(10'd1016, 4'd0);

      // diagonal with gaps gives the same table and results
      load(0, 1'b1);
      run_and_finish(10'd0, 4'd1);

      // timeout: engine never raises Valid
      load(1, 1'b0);
      for (k = 1; k <= 1100; k++) begin
         @(posedge CLK); #1;
         if (done) break;
      end
      exp_cyc = 20'd1000;
      check("to_latency", 32'(k), 1000);
      check("to_err", 32'(err), 1);
      check("to_done", 32'(done), 1);
      check("to_run_cycles", 32'(run_cycles), 32'(exp_cyc));
      check("to_res_min", 32'(res_min), 32'(exp_min));
      check("to_res_cnt", 32'(res_cnt), 32'(exp_cnt));
      check("to_jam_rst", 32'(jam_rst), 1);

      // reset after 30 entries, then full diagonal reload
      for (int i = 0; i < 30; i++) begin
         ld_valid = 1'b1;
         ld_data  = 7'(i + 3);
         @(posedge CLK); #1;
      end
      check("partial_jam_rst", 32'(jam_rst), 1);
      ld_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      exp_min = '0; exp_cnt = '0; exp_cyc = '0;
      check_reset_vals();
      load(0, 1'b0);
      run_and_finish(10'd0, 4'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jam_cost_host.md
# jam_cost_host

Host-side counterpart of the JAM job-assignment engine: it owns the 8×8 worker/job cost table and answers the engine's (W, J) cost lookups. It accepts the 64 costs over a valid/ready load stream, then releases the engine from reset and serves `Cost` combinationally from the table. It captures `MinCost` and `MatchCount` when the engine raises `Valid`, and reports done, or a timeout error if `Valid` never arrives.

## Interface
Parameters:
- `TIMEOUT`, default 400000: RUN-state cycle limit before the error is flagged (must be < 2^20).

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ld_valid`  in  1  load-stream entry valid.
- `ld_data`  in  7  cost entry; entries arrive in row-major order, index = W*8+J.
- `ld_ready`  out  1  host accepts an entry this cycle.
- `jam_rst`  out  1  to engine `RST`; registered.
- `W`  in  3  engine worker address.
- `J`  in  3  engine job address.
- `Cost`  out  7  table[W*8+J]; purely combinational from `W`, `J` and the table registers.
- `Valid`  in  1  engine result valid.
- `MinCost`  in  10  engine minimum cost.
- `MatchCount`  in  4  engine match count.
- `done`  out  1  results held; registered.
- `err`  out  1  timeout occurred; registered.
- `res_min`  out  10  captured `MinCost`.
- `res_cnt`  out  4  captured `MatchCount`.
- `run_cycles`  out  20  RUN-state cycle count at capture or timeout.

## Operation
- States are IDLE, LOAD, RUN and DONE.
- **Reset values:** state=IDLE, `jam_rst`=1, `done`=0, `err`=0, `res_min`=0, `res_cnt`=0, `run_cycles`=0, write index=0. Table contents are not reset; they are fully rewritten before every run.
- **`ld_ready`** = 1 in IDLE, LOAD and DONE; 0 in RUN.
- An entry is accepted when `ld_valid & ld_ready`. An accepted entry writes table[idx] and increments the 6-bit idx.
- **IDLE → LOAD** on the first accepted entry.
- **DONE → LOAD** on an accepted entry, which is written as index 0. On this transition `done` and `err` clear, while `res_min`, `res_cnt` and `run_cycles` keep their values until the next capture.
- **LOAD → RUN** when the entry accepted has idx=63. idx then wraps to 0.
- `ld_valid` gaps in LOAD are legal; state and idx hold during a gap.
- **`jam_rst`** is registered as (next_state != RUN). It is therefore low exactly for the cycles spent in RUN and high otherwise, so the engine is held in reset throughout the load.
- **RUN:**
  - The cycle counter clears on RUN entry and increments each RUN cycle, saturating at 2^20−1.
  - If `Valid`=1: capture `MinCost`→`res_min`, `MatchCount`→`res_cnt`, counter→`run_cycles`; set `done`=1, `err`=0; go to DONE.
  - Else, if the counter reaches `TIMEOUT`−1: set `err`=1, `done`=1, `run_cycles`=`TIMEOUT`; go to DONE. `res_min` and `res_cnt` are unchanged.
  - `Valid` takes priority over timeout in the same cycle.
- `Valid` is ignored outside RUN.
- **DONE:** outputs are held. `jam_rst`=1 holds the engine idle.
- RST asserted in any state, including mid-load or mid-run, returns to reset values on the next edge. A partial load is discarded, and the next load restarts at index 0.

## Timing
- **`Cost`:** zero-cycle latency from `W`/`J`, which the engine samples at the next edge. The table write path must not be read combinationally within the same cycle; the engine never reads during LOAD.
- **Run start:** the last entry is accepted at edge E. State=RUN and `jam_rst`=0 are both visible after E, and the engine leaves its Idle state at edge E+1.
- **Capture:** `Valid` high during RUN cycle n is captured at that cycle's closing edge. `done` rises one cycle after `Valid` is first seen.
- **Load throughput:** one entry per cycle, so a full load takes a minimum of 64 cycles.

## Test plan
- **Diagonal table, paired with the JAM engine:** load cost=0 where W==J, else 100, back-to-back → `done`=1, `err`=0, `res_min`=0, `res_cnt`=1; `Cost` matches the table on every (W,J) the engine presents.
- **All-127 table:** → `res_min`=1016, `res_cnt`=0 (40320 mod 16); `jam_rst` was 1 throughout the load and 0 only during RUN.
- **Handshake gaps:** random `ld_valid` gaps over 64 entries → identical table contents and results to the back-to-back load; `ld_ready`=0 throughout RUN.
- **Timeout:** `TIMEOUT`=1000 with a stub engine that never raises `Valid` → `err`=1 and `done`=1 exactly 1000 cycles after RUN entry; `run_cycles`=1000; `res_min`/`res_cnt` unchanged; `jam_rst`=1.
- **Reset mid-load, then reload:** RST after 30 entries, then a full 64-entry diagonal load → outputs at reset values after RST; the new run gives `res_min`=0, `res_cnt`=1.
- **Reload from DONE:** after a completed run, load the all-127 table → `done`/`err` clear on the first accepted entry; the second run gives `res_min`=1016.
